// File: rtl/conv1d_pkg.sv
// Shared types and default sizing for the conv1d accumulation path.
package conv1d_pkg;

   localparam int DEF_ACC_WIDTH = 32;
   localparam int DEF_MAX_TAPS  = 16;

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      HOLD = 1'b1
   } acc_state_e;

endpackage

// File: rtl/acc_lane.sv
// One lane's combinational accumulate step: sign-extend, add, wrap or saturate, overflow.
// Optional feature: ACC_SAT_EN selects saturating addition instead of two's-complement wrap.
module acc_lane
   import conv1d_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
   input  logic [IN_WIDTH-1:0]  in_lane,
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic                 acc_ovf,
   input  logic                 first,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 ovf
);

   logic signed [IN_WIDTH-1:0] in_signed_s;
   logic [ACC_WIDTH-1:0]       ext_s;
   logic [ACC_WIDTH-1:0]       opb_s;
   logic [ACC_WIDTH:0]         wide_s;
   logic                       add_ovf_s;

   // Operand selection and one-bit-wider add so overflow is visible in the top two bits
   always_comb begin
      in_signed_s = in_lane;
      ext_s       = ACC_WIDTH'(in_signed_s);
      if (first) begin
         opb_s = '0;
      end else begin
         opb_s = acc;
      end
      wide_s    = {ext_s[ACC_WIDTH-1], ext_s} + {opb_s[ACC_WIDTH-1], opb_s};
      add_ovf_s = (wide_s[ACC_WIDTH] != wide_s[ACC_WIDTH-1]);
   end

   // Result shaping and sticky overflow; the first beat starts a clean window
   always_comb begin
`ifdef ACC_SAT_EN
      if (add_ovf_s && wide_s[ACC_WIDTH]) begin
         sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else if (add_ovf_s) begin
         sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         sum = wide_s[ACC_WIDTH-1:0];
      end
`else
      sum = wide_s[ACC_WIDTH-1:0];
`endif
      if (first) begin
         ovf = add_ovf_s;
      end else begin
         ovf = add_ovf_s | acc_ovf;
      end
   end

endmodule

// File: rtl/acc_array.sv
// Multi-lane windowed accumulator with one-deep result buffering and valid/ready on both sides.
// Optional feature: ACC_SAT_EN (saturating lane addition, see acc_lane).
module acc_array
   import conv1d_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int NUM_CH    = 4,
   parameter int MAX_TAPS  = DEF_MAX_TAPS,
   localparam int TW       = $clog2(MAX_TAPS + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [TW-1:0]                 cfg_taps,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_CH*IN_WIDTH-1:0]    in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_CH*ACC_WIDTH-1:0]   out_data,
   output logic [NUM_CH-1:0]             out_ovf
);

   acc_state_e                    state_r;
   acc_state_e                    state_nxt_s;
   logic [TW-1:0]                 tap_cnt_r;
   logic [TW-1:0]                 taps_q_r;
   logic [NUM_CH*ACC_WIDTH-1:0]   acc_r;
   logic [NUM_CH-1:0]             acc_ovf_r;
   logic                          out_valid_r;
   logic [NUM_CH*ACC_WIDTH-1:0]   out_data_r;
   logic [NUM_CH-1:0]             out_ovf_r;

   logic [TW-1:0]                 taps_eff_s;
   logic [TW-1:0]                 cur_taps_s;
   logic                          first_s;
   logic                          last_s;
   logic                          in_ready_s;
   logic                          accept_s;
   logic                          out_hs_s;
   logic                          out_free_s;
   logic [NUM_CH*ACC_WIDTH-1:0]   sum_s;
   logic [NUM_CH-1:0]             sum_ovf_s;

   logic load_out_sum_s;
   logic load_out_acc_s;
   logic load_acc_s;
   logic latch_taps_s;
   logic clr_cnt_s;
   logic inc_cnt_s;

   // Tap count sanitising and handshake qualifiers
   always_comb begin
      if (cfg_taps == TW'(0)) begin
         taps_eff_s = TW'(1);
      end else if (cfg_taps > TW'(MAX_TAPS)) begin
         taps_eff_s = TW'(MAX_TAPS);
      end else begin
         taps_eff_s = cfg_taps;
      end
      first_s = (tap_cnt_r == TW'(0));
      if (first_s) begin
         cur_taps_s = taps_eff_s;
      end else begin
         cur_taps_s = taps_q_r;
      end
      last_s     = (tap_cnt_r == (cur_taps_s - TW'(1)));
      in_ready_s = rst_n && !flush && (state_r == ACC);
      accept_s   = in_valid && in_ready_s;
      out_hs_s   = out_valid_r && out_ready;
      out_free_s = !out_valid_r || out_ready;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      acc_lane #(
         .IN_WIDTH  (IN_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
         .in_lane (in_data[k*IN_WIDTH +: IN_WIDTH]),
         .acc     (acc_r[k*ACC_WIDTH +: ACC_WIDTH]),
         .acc_ovf (acc_ovf_r[k]),
         .first   (first_s),
         .sum     (sum_s[k*ACC_WIDTH +: ACC_WIDTH]),
         .ovf     (sum_ovf_s[k])
      );
   end

   // Next-state and datapath control
   always_comb begin
      state_nxt_s    = state_r;
      load_out_sum_s = 1'b0;
      load_out_acc_s = 1'b0;
      load_acc_s     = 1'b0;
      latch_taps_s   = 1'b0;
      clr_cnt_s      = 1'b0;
      inc_cnt_s      = 1'b0;
      if (flush) begin
         state_nxt_s = ACC;
         clr_cnt_s   = 1'b1;
      end else begin
         case (state_r)
            ACC: begin
               if (accept_s) begin
                  latch_taps_s = first_s;
                  if (last_s && out_free_s) begin
                     load_out_sum_s = 1'b1;
                     clr_cnt_s      = 1'b1;
                  end else if (last_s) begin
                     load_acc_s  = 1'b1;
                     state_nxt_s = HOLD;
                  end else begin
                     load_acc_s = 1'b1;
                     inc_cnt_s  = 1'b1;
                  end
               end else begin
                  state_nxt_s = ACC;
               end
            end
            HOLD: begin
               if (out_hs_s) begin
                  load_out_acc_s = 1'b1;
                  clr_cnt_s      = 1'b1;
                  state_nxt_s    = ACC;
               end else begin
                  state_nxt_s = HOLD;
               end
            end
            default: begin
               state_nxt_s = ACC;
               clr_cnt_s   = 1'b1;
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ACC;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Tap counter, window accumulator and output holding registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tap_cnt_r   <= '0;
         taps_q_r    <= '0;
         acc_r       <= '0;
         acc_ovf_r   <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_ovf_r   <= '0;
      end else begin
         if (clr_cnt_s) begin
            tap_cnt_r <= '0;
         end else if (inc_cnt_s) begin
            tap_cnt_r <= tap_cnt_r + TW'(1);
         end
         if (latch_taps_s) begin
            taps_q_r <= taps_eff_s;
         end
         if (load_acc_s) begin
            acc_r     <= sum_s;
            acc_ovf_r <= sum_ovf_s;
         end
         if (load_out_sum_s) begin
            out_data_r  <= sum_s;
            out_ovf_r   <= sum_ovf_s;
            out_valid_r <= 1'b1;
         end else if (load_out_acc_s) begin
            out_data_r  <= acc_r;
            out_ovf_r   <= acc_ovf_r;
            out_valid_r <= 1'b1;
         end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_acc_array.sv
// Randomised self-checking bench for acc_array against a queue-based window model.
module tb_acc_array;

   localparam int TW = 5;

   typedef struct {
      logic [127:0] data;
      logic [3:0]   ovf;
   } result_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [TW-1:0] cfg_taps;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   out_ovf;

   logic [TW-1:0] cfg_taps_b;
   logic         in_valid_b;
   logic         in_ready_b;
   logic [15:0]  in_data_b;
   logic         out_valid_b;
   logic         out_ready_b;
   logic [15:0]  out_data_b;
   logic [0:0]   out_ovf_b;

   int n_checks = 0;
   int n_pass   = 0;

   result_t exp_q[$];
   int      cnt_m;
   int      taps_m;
   longint  sum_m[4];
   bit      ovf_m[4];

   always #5 clk = ~clk;

   acc_array dut (
      .clk(clk), .rst_n(rst_n), .cfg_taps(cfg_taps), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
   );

   acc_array #(.IN_WIDTH(16), .ACC_WIDTH(16), .NUM_CH(1), .MAX_TAPS(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .cfg_taps(cfg_taps_b), .flush(1'b0),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_ovf(out_ovf_b)
   );

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic longint add_w(input longint a, input longint b, input int w, output bit ov);
      longint s  = a + b;
      longint mx = (longint'(1) <<< (w - 1)) - 1;
      longint mn = -mx - 1;
      ov = (s > mx) || (s < mn);
`ifdef ACC_SAT_EN
      if (s > mx) s = mx;
      else if (s < mn) s = mn;
`else
      if (s > mx) s = s - 2 * (mx + 1);
      else if (s < mn) s = s + 2 * (mx + 1);
`endif
      return s;
   endfunction

   function automatic int eff_taps(input int t);
      if (t == 0) return 1;
      if (t > 16) return 16;
      return t;
   endfunction

   // One clock of stimulus on the main DUT; compares at negedge, then advances the model
   task automatic cycle(input bit v, input logic [63:0] d, input bit rdy, input bit fl, input int taps);
      bit exp_rdy, hs, acc, held;
      result_t r;
      in_valid = v; in_data = d; out_ready = rdy; flush = fl; cfg_taps = TW'(taps);
      @(negedge clk);
      exp_rdy = !fl && (exp_q.size() < 2);
      check_eq("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
      check_eq("out_valid", {127'd0, out_valid}, {127'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
         check_eq("out_data", out_data, exp_q[0].data);
         check_eq("out_ovf", {124'd0, out_ovf}, {124'd0, exp_q[0].ovf});
      end
      hs   = (exp_q.size() > 0) && rdy;
      acc  = v && exp_rdy;
      held = (exp_q.size() == 2);
      if (hs) void'(exp_q.pop_front());
      if (fl) begin
         cnt_m = 0;
         if (held) void'(exp_q.pop_back());
      end else if (acc) begin
         if (cnt_m == 0) taps_m = eff_taps(taps);
         for (int k = 0; k < 4; k++) begin
            logic signed [15:0] x;
            bit o;
            x = d[k*16 +: 16];
            if (cnt_m == 0) begin
               sum_m[k] = longint'(x);
               ovf_m[k] = 1'b0;
            end else begin
               sum_m[k] = add_w(sum_m[k], longint'(x), 32, o);
               ovf_m[k] = ovf_m[k] | o;
            end
         end
         cnt_m++;
         if (cnt_m == taps_m) begin
            for (int k = 0; k < 4; k++) begin
               longint s;
               s = sum_m[k];
               r.data[k*32 +: 32] = s[31:0];
               r.ovf[k] = ovf_m[k];
            end
            exp_q.push_back(r);
            cnt_m = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check_eq("in_ready_in_reset", {127'd0, in_ready}, 128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check_eq("rst_out_data", out_data, 128'd0);
      check_eq("rst_out_ovf", {124'd0, out_ovf}, 128'd0);
      exp_q.delete();
      cnt_m = 0;
   endtask

   initial begin
      logic [63:0] d;
      logic [15:0] exp_b;
      rst_n = 1'b0; cfg_taps = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      cfg_taps_b = TW'(2); in_valid_b = 1'b0; in_data_b = 16'h0000; out_ready_b = 1'b1;
      cnt_m = 0; taps_m = 1;
      @(posedge clk); #1;
      do_reset();

      // 16-bit overflow window on the narrow instance
      in_valid_b = 1'b1; in_data_b = 16'h7000;
      @(posedge clk); @(posedge clk); #1;
      in_valid_b = 1'b0;
      @(negedge clk);
`ifdef ACC_SAT_EN
      exp_b = 16'h7FFF;
`else
      exp_b = 16'hE000;
`endif
      check_eq("ovf16_valid", {127'd0, out_valid_b}, {127'd0, 1'b1});
      check_eq("ovf16_data", {112'd0, out_data_b}, {112'd0, exp_b});
      check_eq("ovf16_flag", {127'd0, out_ovf_b}, {127'd0, 1'b1});
      @(posedge clk); #1;

      // basic window
      for (int i = 0; i < 3; i++) cycle(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0, 3);
      check_eq("basic_data", out_data, {32'd12, 32'd9, 32'd6, 32'd3});
      for (int i = 0; i < 2; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 3);

      // backpressure: two windows absorbed, then release
      for (int i = 0; i < 6; i++) cycle(1'b1, {4{16'd5}}, 1'b0, 1'b0, 2);
      for (int i = 0; i < 4; i++) cycle(1'b1, {4{16'd5}}, 1'b1, 1'b0, 2);
      for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 2);

      // flush mid-window
      for (int i = 0; i < 2; i++) cycle(1'b1, {4{16'd7}}, 1'b1, 1'b0, 4);
      cycle(1'b1, {4{16'd7}}, 1'b1, 1'b1, 4);
      for (int i = 0; i < 4; i++) cycle(1'b1, {4{16'd1}}, 1'b1, 1'b0, 4);
      check_eq("flush_data", out_data, {4{32'd4}});
      cycle(1'b0, 64'd0, 1'b1, 1'b0, 4);

      // cfg_taps change mid-window, then taps of 0
      cycle(1'b1, {4{16'd3}}, 1'b1, 1'b0, 2);
      for (int i = 0; i < 6; i++) cycle(1'b1, {4{16'd3}}, 1'b1, 1'b0, 5);
      for (int i = 0; i < 4; i++) cycle(1'b1, {4{16'hFFF0}}, 1'b1, 1'b0, 0);
      for (int i = 0; i < 2; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 0);

      // reset with a held result and a partial window
      for (int i = 0; i < 3; i++) cycle(1'b1, {4{16'd9}}, 1'b0, 1'b0, 2);
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, {4{16'd2}}, 1'b1, 1'b0, 2);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         d = {$urandom, $urandom};
         cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
               $urandom_range(0, 40) == 0, int'($urandom_range(0, 18)));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/acc_array.md
# acc_array

Multi-channel, handshaked successor to the single-lane conv1d accumulator. It sums a runtime-programmable number of taps per output sample on `NUM_CH` parallel lanes and double-buffers the result: an accumulation stage feeds an output holding stage. It sits between the conv1d MAC array, which supplies per-channel partial products, and the output writeback path, with valid/ready handshakes on both sides.

## Interface
- `IN_WIDTH`, 16, signed width of one lane's partial product
- `ACC_WIDTH`, 32, signed accumulator/result width per lane; must be ≥ `IN_WIDTH`
- `NUM_CH`, 4, number of parallel lanes
- `MAX_TAPS`, 16, largest supported taps per window
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `cfg_taps` in `$clog2(MAX_TAPS+1)`: taps per output window; 0 is treated as 1; values > `MAX_TAPS` are clamped
- `flush` in 1: abort the current window
- `in_valid` in 1: input beat valid
- `in_ready` out 1: block accepts a beat
- `in_data` in `NUM_CH*IN_WIDTH`: lane k occupies bits `[k*IN_WIDTH +: IN_WIDTH]`
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts the result
- `out_data` out `NUM_CH*ACC_WIDTH`: per-lane sums, packed the same way as `in_data`
- `out_ovf` out `NUM_CH`: per-lane overflow flag of the presented result

## Operation
- **Beat acceptance:** a beat is accepted when `in_valid && in_ready`. `in_data` lanes are sign-extended to `ACC_WIDTH`.
- **Tap counter:** `tap_cnt` counts accepted beats. `cfg_taps` is latched into `taps_q` when the first beat of a window is accepted (`tap_cnt==0`).
- **First beat of a window:** the accumulator loads the extended input directly, i.e. the adder's second operand is zero, and per-lane overflow is cleared.
- **Later beats:** `acc += ext(in)`. Overflow is sticky for the rest of the window.
- **FSM, two states:**
  - `ACC`: `in_ready=1`. When the last beat (`tap_cnt==taps_q-1`) is accepted:
    - If the output stage is free (`!out_valid || out_ready`), the sum and ovf go straight to the output registers, `out_valid` becomes 1, `tap_cnt` becomes 0, and the FSM stays in `ACC`.
    - Otherwise the sum is stored in `acc` and the FSM moves to `HOLD`.
  - `HOLD`: `in_ready=0`. On an output handshake, `acc` and ovf move to the output registers, `out_valid` stays 1, `tap_cnt` becomes 0, and the FSM returns to `ACC`.
- **Output stage:** when an output handshake occurs and nothing new is loaded, `out_valid` falls to 0.
- **`flush`:** while `flush=1`, `in_ready=0`. One cycle of `flush` discards the partial window, so `tap_cnt=0` and the FSM goes to `ACC`, including from `HOLD`. The output registers are untouched and keep completing their handshake normally.
- **Reset:** while `rst_n=0`, `in_ready=0`. On the following edge:
  - FSM is `ACC`
  - `tap_cnt`, `taps_q` and `acc` are 0
  - `out_valid=0`, `out_data=0`, `out_ovf=0`

  Any partial window in progress at reset is discarded.

## Timing
- **Latency:** `out_valid` rises in the cycle after the last beat is accepted.
- **Throughput:** one beat per cycle, sustained while `out_ready=1`. With `cfg_taps=1`, one result per cycle.
- **Back-to-back windows:** need no idle cycle.
- **Simultaneous output handshake and last beat in `ACC`:** the new result replaces the old one and `out_valid` stays high, with no bubble.
- **Backpressure:** when the output stage is full, at most one completed window is absorbed in `acc`. `in_ready` then drops in the following cycle.
- **Handshake rules:**
  - `out_data` and `out_ovf` are stable while `out_valid && !out_ready`.
  - `out_valid` never depends combinationally on `out_ready`.
  - `in_ready` depends only on the FSM state, `flush` and `rst_n`.

## Configuration
- **`ACC_SAT_EN` defined:** each addition saturates to the signed `ACC_WIDTH` range (`0x7FFF_FFFF` / `0x8000_0000` at 32 bits). Saturation sets the lane's overflow flag.
- **`ACC_SAT_EN` undefined:** additions wrap two's-complement, and the overflow flag records signed overflow only (same-sign operands giving an opposite-sign sum).
- `out_ovf` exists in both builds.

## Structure
- **Package `conv1d_pkg`:** holds the `acc_state_e` enum (`ACC`, `HOLD`) and the `DEF_ACC_WIDTH` and `DEF_MAX_TAPS` constants.
- **Sub-module `acc_lane`:** one per channel, instantiated `NUM_CH` times. It contains the sign-extend, the zero/accumulator operand mux, the adder, saturate-or-wrap logic and overflow detection, and is purely combinational.
- **Top level:** the FSM, tap counter, `acc` registers and output registers live in `acc_array`.

## Test plan
- **Basic window:** `cfg_taps=3`, `NUM_CH=4`, lane inputs `{1,2,3,4}` ×3 beats, `out_ready=1` → `out_data` lanes `{3,6,9,12}` one cycle after the third beat, `out_ovf=0`.
- **Backpressure:** `cfg_taps=2`, `out_ready=0`, 6 beats of value 5 offered → first result 10 held stable; second window absorbed into `HOLD`; `in_ready=0` after 4 accepted beats. Raising `out_ready` releases 10, then 10, then accepts beats again.
- **Overflow:** `ACC_WIDTH=IN_WIDTH=16`, two beats of `0x7000` →
  - with `ACC_SAT_EN`: result `0x7FFF`, `out_ovf=1`
  - without: result `0xE000`, `out_ovf=1`
- **Flush mid-window:** `cfg_taps=4`, 2 beats of 7, then `flush` for one cycle, then 4 beats of 1 → a single result of 4, with no stale 14 contribution.
- **`cfg_taps` change mid-window:** `cfg_taps` changes from 2 to 5 during a window → the current window still closes after 2 beats; the next uses 5. `cfg_taps=0` behaves as 1, i.e. one result per beat.
- **Reset mid-operation:** `rst_n` pulsed low during a partial window and with `out_valid=1` → the next cycle shows `out_valid=0` and `in_ready=1`; the subsequent window sums only post-reset beats.
